// File: rtl/prog_tick_timer.sv
// Programmable tick timer: a free-running prescaler divides clk into a base
// tick, and a loadable down-counter counts base ticks.
// The timer pulses tick on expiry, either once (one-shot) or repeatedly with
// auto-reload (periodic). start, stop and enable give run-time control.
module prog_tick_timer #(
  parameter int PRESCALE  = 50_000_000,
  parameter int CNT_WIDTH = 8,
  parameter int PRE_WIDTH = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 periodic,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 base_tick,
  output logic                 tick,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [PRE_WIDTH-1:0] PRE_MAX = PRE_WIDTH'(PRESCALE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                 state_q,  state_d;
  logic [PRE_WIDTH-1:0]   pre_q,    pre_d;
  logic [CNT_WIDTH-1:0]   count_q,  count_d;
  logic [CNT_WIDTH-1:0]   reload_q, reload_d;
  logic                   mode_q,   mode_d;
  logic                   tick_q,   tick_d;
  logic                   base_q,   base_d;
  logic                   wrap;

  // The prescaler only advances while enabled, so a pause stretches every
  // interval by exactly the number of frozen cycles.
  assign wrap = enable && (pre_q == PRE_MAX);

  // Next-state and next-output logic for the prescaler, counter and FSM.
  // NOTE: every variable gets a default at the top of always_comb; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    base_d   = wrap;

    if (enable) begin
      pre_d = wrap ? '0 : pre_q + 1'b1;
    end

    // start wins over stop; a zero period is not a valid run and is ignored.
    if (start && (load_val != '0)) begin
      count_d  = load_val;
      reload_d = load_val;
      mode_d   = periodic;
      pre_d    = '0;
      state_d  = RUN;
    end else if (stop) begin
      count_d  = '0;
      state_d  = IDLE;
    end else if ((state_q == RUN) && wrap) begin
      if (count_q == CNT_ONE) begin
        tick_d = 1'b1;
        if (mode_q) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // State register; all timer state clears as soon as reset rises.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      base_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      base_q   <= base_d;
    end
  end

  assign tick      = tick_q;
  assign base_tick = base_q;
  assign running   = (state_q == RUN);
  assign count     = count_q;

endmodule

// File: tb/tb_prog_tick_timer.sv
// Bench for prog_tick_timer. Two instances share one clock: PRESCALE=4 and
// PRESCALE=1. Both are compared on every cycle against a reference model.
// The model derives expected outputs from the number of enabled cycles since
// the last start.
module tb_prog_tick_timer;

  logic       clk;
  logic       rst;
  logic       en_i  [2];
  logic       st_i  [2];
  logic       sp_i  [2];
  logic       per_i [2];
  logic [7:0] lv_i  [2];
  logic       base_o[2];
  logic       tick_o[2];
  logic       run_o [2];
  logic [7:0] cnt_o [2];

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  int ntick[2];
  int first_tick[2];

  // reference model state
  int en_since[2];
  bit run_m[2];
  bit per_m[2];
  int len_m[2];
  int cnt_m[2];
  bit tick_m[2];
  bit base_m[2];

  prog_tick_timer #(.PRESCALE(4), .CNT_WIDTH(8), .PRE_WIDTH(3)) dut4 (
    .clk(clk), .reset(rst), .enable(en_i[0]), .start(st_i[0]), .stop(sp_i[0]),
    .periodic(per_i[0]), .load_val(lv_i[0]), .base_tick(base_o[0]),
    .tick(tick_o[0]), .running(run_o[0]), .count(cnt_o[0])
  );

  prog_tick_timer #(.PRESCALE(1), .CNT_WIDTH(8), .PRE_WIDTH(1)) dut1 (
    .clk(clk), .reset(rst), .enable(en_i[1]), .start(st_i[1]), .stop(sp_i[1]),
    .periodic(per_i[1]), .load_val(lv_i[1]), .base_tick(base_o[1]),
    .tick(tick_o[1]), .running(run_o[1]), .count(cnt_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pval(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    en_since[d] = 0;
    run_m[d]    = 1'b0;
    per_m[d]    = 1'b0;
    len_m[d]    = 0;
    cnt_m[d]    = 0;
    tick_m[d]   = 1'b0;
    base_m[d]   = 1'b0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_step(input int d);
    int p;
    int period;
    p = pval(d);
    if (rst) begin
      model_reset(d);
    end else begin
      base_m[d] = en_i[d] && (((en_since[d] + 1) % p) == 0);
      tick_m[d] = 1'b0;
      if (st_i[d] && (lv_i[d] != 8'd0)) begin
        run_m[d]    = 1'b1;
        per_m[d]    = per_i[d];
        len_m[d]    = int'(lv_i[d]);
        cnt_m[d]    = int'(lv_i[d]);
        en_since[d] = 0;
      end else if (sp_i[d]) begin
        run_m[d] = 1'b0;
        cnt_m[d] = 0;
        if (en_i[d]) en_since[d]++;
      end else if (en_i[d]) begin
        en_since[d]++;
        if (run_m[d]) begin
          period = len_m[d] * p;
          if ((en_since[d] % period) == 0) begin
            tick_m[d] = 1'b1;
            if (per_m[d]) begin
              cnt_m[d] = len_m[d];
            end else begin
              run_m[d] = 1'b0;
              cnt_m[d] = 0;
            end
          end else begin
            cnt_m[d] = len_m[d] - (en_since[d] % period) / p;
          end
        end
      end
    end
  endtask

  task automatic compare(input int d);
    check($sformatf("d%0d.tick@%0d", d, cyc_n), 32'(tick_o[d]), 32'(tick_m[d]));
    check($sformatf("d%0d.base_tick@%0d", d, cyc_n), 32'(base_o[d]), 32'(base_m[d]));
    check($sformatf("d%0d.running@%0d", d, cyc_n), 32'(run_o[d]), 32'(run_m[d]));
    check($sformatf("d%0d.count@%0d", d, cyc_n), 32'(cnt_o[d]), 32'(cnt_m[d]));
  endtask

  // Advance one clock: model at the edge, compare 1 ns later, return at negedge.
  task automatic cyc();
    @(posedge clk);
    cyc_n++;
    for (int d = 0; d < 2; d++) model_step(d);
    #1;
    for (int d = 0; d < 2; d++) begin
      compare(d);
      if (tick_o[d] === 1'b1) begin
        if (ntick[d] == 0) first_tick[d] = cyc_n;
        ntick[d]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      ntick[d]      = 0;
      first_tick[d] = -1;
    end
  endtask

  task automatic go(input int d, input logic [7:0] lv, input logic per);
    lv_i[d]  = lv;
    per_i[d] = per;
    st_i[d]  = 1'b1;
    cyc();
    st_i[d]  = 1'b0;
  endtask

  task automatic halt(input int d);
    sp_i[d] = 1'b1;
    cyc();
    sp_i[d] = 1'b0;
  endtask

  initial begin
    int s;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      en_i[d] = 1'b0; st_i[d] = 1'b0; sp_i[d] = 1'b0; per_i[d] = 1'b0; lv_i[d] = 8'd0;
      model_reset(d);
    end
    clear_counts();
    @(negedge clk);
    run_cycles(3);
    rst = 1'b0;
    en_i[0] = 1'b1;
    en_i[1] = 1'b1;
    run_cycles(2);
    check("reset.running", 32'(run_o[0]), 32'd0);
    check("reset.count", 32'(cnt_o[0]), 32'd0);

    // one-shot, load 3: single tick 12 cycles after start
    go(0, 8'd3, 1'b0);
    s = cyc_n;
    clear_counts();
    run_cycles(112);
    check("oneshot.ticks", 32'(ntick[0]), 32'd1);
    check("oneshot.latency", 32'(first_tick[0] - s), 32'd12);
    check("oneshot.count", 32'(cnt_o[0]), 32'd0);

    // periodic, load 3: ticks at +12, +24, +36
    go(0, 8'd3, 1'b1);
    s = cyc_n;
    clear_counts();
    run_cycles(38);
    check("periodic.ticks", 32'(ntick[0]), 32'd3);
    check("periodic.first", 32'(first_tick[0] - s), 32'd12);
    halt(0);

    // pause 5 cycles mid-period: tick moves out by exactly 5
    go(0, 8'd3, 1'b1);
    s = cyc_n;
    clear_counts();
    run_cycles(6);
    en_i[0] = 1'b0;
    run_cycles(5);
    check("pause.count_frozen", 32'(cnt_o[0]), 32'd2);
    en_i[0] = 1'b1;
    run_cycles(10);
    check("pause.first", 32'(first_tick[0] - s), 32'd17);
    halt(0);

    // stop at +9 of a 5-tick run
    go(0, 8'd5, 1'b0);
    clear_counts();
    run_cycles(8);
    halt(0);
    check("stop.running", 32'(run_o[0]), 32'd0);
    check("stop.count", 32'(cnt_o[0]), 32'd0);
    run_cycles(30);
    check("stop.ticks", 32'(ntick[0]), 32'd0);
    sp_i[0] = 1'b1;
    go(0, 8'd5, 1'b0);
    sp_i[0] = 1'b0;
    check("start_over_stop.running", 32'(run_o[0]), 32'd1);
    halt(0);

    // zero load ignored; restart discards the earlier run
    go(0, 8'd0, 1'b1);
    check("zero_load.running", 32'(run_o[0]), 32'd0);
    go(0, 8'd5, 1'b0);
    clear_counts();
    run_cycles(6);
    go(0, 8'd2, 1'b0);
    s = cyc_n;
    run_cycles(20);
    check("restart.ticks", 32'(ntick[0]), 32'd1);
    check("restart.latency", 32'(first_tick[0] - s), 32'd8);

    // PRESCALE=1, load 1 periodic: tick every cycle
    go(1, 8'd1, 1'b1);
    clear_counts();
    run_cycles(10);
    check("p1.ticks", 32'(ntick[1]), 32'd10);

    // asynchronous reset mid-cycle clears outputs at once
    go(0, 8'd4, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      check($sformatf("areset.d%0d.tick", d), 32'(tick_o[d]), 32'd0);
      check($sformatf("areset.d%0d.base", d), 32'(base_o[d]), 32'd0);
      check($sformatf("areset.d%0d.running", d), 32'(run_o[d]), 32'd0);
      check($sformatf("areset.d%0d.count", d), 32'(cnt_o[d]), 32'd0);
    end
    @(negedge clk);
    run_cycles(2);
    rst = 1'b0;
    clear_counts();
    run_cycles(10);
    check("areset.no_tick_p1", 32'(ntick[1]), 32'd0);
    check("areset.no_tick_p4", 32'(ntick[0]), 32'd0);

    // randomized control traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        en_i[d]  = ($urandom_range(0, 7) != 0);
        st_i[d]  = ($urandom_range(0, 19) == 0);
        sp_i[d]  = ($urandom_range(0, 39) == 0);
        per_i[d] = $urandom_range(0, 1) == 1;
        lv_i[d]  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2))
                                               : 8'($urandom_range(0, 12));
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
